// File: rtl/decode_issue_queue_if.sv
// Fetch-side handshake and issue bus of the decode/issue queue.
// The slave modport is the queue's own view; master is the surrounding pipeline.
interface decode_issue_queue_if #(
  parameter int ROB_W = 4
);
  // fetch side
  logic              fetch_valid;
  logic [31:0]       fetch_inst;
  logic [31:0]       fetch_pc;
  logic              fetch_pred_jump;
  logic              fetch_ready;
  // issue side
  logic              issue_enable;
  logic              issue_to_rs;
  logic              issue_to_lsb;
  logic [6:0]        issue_opcode;
  logic [2:0]        issue_funct3;
  logic              issue_funct7b5;
  logic [4:0]        issue_rd;
  logic [31:0]       issue_rs1_val;
  logic [31:0]       issue_rs2_val;
  logic [ROB_W-1:0]  issue_rs1_rob_pos;
  logic [ROB_W-1:0]  issue_rs2_rob_pos;
  logic [31:0]       issue_imm;
  logic [31:0]       issue_pc;
  logic              issue_pred_jump;
  logic              issue_ready_inst;
  logic [ROB_W-1:0]  issue_rob_pos;

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc, fetch_pred_jump,
    output fetch_ready,
    output issue_enable, issue_to_rs, issue_to_lsb, issue_opcode, issue_funct3,
           issue_funct7b5, issue_rd, issue_rs1_val, issue_rs2_val,
           issue_rs1_rob_pos, issue_rs2_rob_pos, issue_imm, issue_pc,
           issue_pred_jump, issue_ready_inst, issue_rob_pos
  );

  modport master (
    output fetch_valid, fetch_inst, fetch_pc, fetch_pred_jump,
    input  fetch_ready,
    input  issue_enable, issue_to_rs, issue_to_lsb, issue_opcode, issue_funct3,
           issue_funct7b5, issue_rd, issue_rs1_val, issue_rs2_val,
           issue_rs1_rob_pos, issue_rs2_rob_pos, issue_imm, issue_pc,
           issue_pred_jump, issue_ready_inst, issue_rob_pos
  );
endinterface

// File: rtl/decode_issue_queue.sv
// Decode/issue queue: buffers fetched instructions, decodes the head entry,
// resolves its operands (regfile / ROB / CDB bypass) and issues one registered
// instruction per cycle to the RS or LSB.
module decode_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 4,
  parameter int CDB_CH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy_i,
  input  logic                      rollback_i,
  decode_issue_queue_if.slave       bus,
  output logic [4:0]                reg_rs1_pos_o,
  output logic [4:0]                reg_rs2_pos_o,
  input  logic [31:0]               reg_rs1_val_i,
  input  logic [31:0]               reg_rs2_val_i,
  input  logic [ROB_W-1:0]          reg_rs1_rob_pos_i,
  input  logic [ROB_W-1:0]          reg_rs2_rob_pos_i,
  output logic [ROB_W-1:0]          rob_rs1_pos_o,
  output logic [ROB_W-1:0]          rob_rs2_pos_o,
  input  logic                      rob_rs1_ready_i,
  input  logic                      rob_rs2_ready_i,
  input  logic [31:0]               rob_rs1_val_i,
  input  logic [31:0]               rob_rs2_val_i,
  input  logic [ROB_W-1:0]          next_rob_pos_i,
  input  logic                      rob_full_i,
  input  logic                      rs_full_i,
  input  logic                      lsb_full_i,
  input  logic [CDB_CH-1:0]         cdb_valid_i,
  input  logic [CDB_CH*ROB_W-1:0]   cdb_rob_pos_i,
  input  logic [CDB_CH*32-1:0]      cdb_val_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_jump;
  } entry_t;

  typedef struct packed {
    logic [31:0]      val;
    logic [ROB_W-1:0] tag;
  } operand_t;

  typedef struct packed {
    logic             enable;
    logic             to_rs;
    logic             to_lsb;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [4:0]       rd;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic [ROB_W-1:0] rs1_rob_pos;
    logic [ROB_W-1:0] rs2_rob_pos;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic             pred_jump;
    logic             ready_inst;
    logic [ROB_W-1:0] rob_pos;
  } issue_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  issue_t             issue_q, issue_d;

  entry_t             head;
  logic [6:0]         opcode;
  logic               to_rs, to_lsb, use_rs1, use_rs2, no_rd, is_store;
  logic [31:0]        imm;
  operand_t           op1, op2;
  logic               fetch_ready, enq, go;

  // Operand lookup; later overrides carry higher priority:
  // tag 0 -> regfile, then ready ROB entry, then lowest matching CDB channel.
  function automatic operand_t resolve(
    input logic [ROB_W-1:0]        tag,
    input logic [31:0]             reg_val,
    input logic                    rob_ready,
    input logic [31:0]             rob_val,
    input logic [CDB_CH-1:0]       cdb_valid,
    input logic [CDB_CH*ROB_W-1:0] cdb_pos,
    input logic [CDB_CH*32-1:0]    cdb_val
  );
    operand_t res;
    res.val = '0;
    res.tag = tag;
    for (int c = CDB_CH - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_pos[c*ROB_W +: ROB_W] == tag)) begin
        res.val = cdb_val[c*32 +: 32];
        res.tag = '0;
      end
    end
    if (rob_ready) begin
      res.val = rob_val;
      res.tag = '0;
    end
    if (tag == '0) begin
      res.val = reg_val;
      res.tag = '0;
    end
    return res;
  endfunction

  assign head          = mem_q[head_q];
  assign opcode        = head.inst[6:0];
  assign reg_rs1_pos_o = head.inst[19:15];
  assign reg_rs2_pos_o = head.inst[24:20];
  assign rob_rs1_pos_o = reg_rs1_rob_pos_i;
  assign rob_rs2_pos_o = reg_rs2_rob_pos_i;

  // Classify the head opcode: destination station, used operands, immediate.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    to_rs    = 1'b0;
    to_lsb   = 1'b0;
    use_rs1  = 1'b1;
    use_rs2  = 1'b1;
    no_rd    = 1'b0;
    is_store = 1'b0;
    imm      = '0;
    case (opcode)
      OPC_OP:     to_rs = 1'b1;
      OPC_OP_IMM: begin
        to_rs = 1'b1; use_rs2 = 1'b0;
        imm   = {{20{head.inst[31]}}, head.inst[31:20]};
      end
      OPC_LOAD: begin
        to_lsb = 1'b1; use_rs2 = 1'b0;
        imm    = {{20{head.inst[31]}}, head.inst[31:20]};
      end
      OPC_JALR: begin
        to_rs = 1'b1; use_rs2 = 1'b0;
        imm   = {{20{head.inst[31]}}, head.inst[31:20]};
      end
      OPC_STORE: begin
        to_lsb = 1'b1; no_rd = 1'b1; is_store = 1'b1;
        imm    = {{20{head.inst[31]}}, head.inst[31:25], head.inst[11:7]};
      end
      OPC_BRANCH: begin
        to_rs = 1'b1; no_rd = 1'b1;
        imm   = {{19{head.inst[31]}}, head.inst[31], head.inst[7],
                 head.inst[30:25], head.inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        to_rs = 1'b1; use_rs1 = 1'b0; use_rs2 = 1'b0;
        imm   = {{11{head.inst[31]}}, head.inst[31], head.inst[19:12],
                 head.inst[20], head.inst[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        to_rs = 1'b1; use_rs1 = 1'b0; use_rs2 = 1'b0;
        imm   = {head.inst[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Resolve both head operands; unused operands collapse to value 0, tag 0.
  always_comb begin
    op1 = resolve(reg_rs1_rob_pos_i, reg_rs1_val_i, rob_rs1_ready_i, rob_rs1_val_i,
                  cdb_valid_i, cdb_rob_pos_i, cdb_val_i);
    op2 = resolve(reg_rs2_rob_pos_i, reg_rs2_val_i, rob_rs2_ready_i, rob_rs2_val_i,
                  cdb_valid_i, cdb_rob_pos_i, cdb_val_i);
    if (!use_rs1) op1 = '0;
    if (!use_rs2) op2 = '0;
  end

  assign fetch_ready     = (count_q != CNT_W'(DEPTH));
  assign bus.fetch_ready = fetch_ready;
  assign enq = bus.fetch_valid && fetch_ready && !rollback_i;
  // Unknown opcodes also dequeue on go, but produce no issue pulse.
  assign go  = (count_q != '0) && !rob_full_i && !(to_rs && rs_full_i)
            && !(to_lsb && lsb_full_i) && !rollback_i;

  // Queue pointer/occupancy next state; rollback empties the queue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rollback_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (go)  head_d = head_q + PTR_W'(1);
      case ({enq, go})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next issue register: pulse enable on a real issue, otherwise hold fields.
  always_comb begin
    issue_d        = issue_q;
    issue_d.enable = 1'b0;
    if (go && (to_rs || to_lsb)) begin
      issue_d.enable      = 1'b1;
      issue_d.to_rs       = to_rs;
      issue_d.to_lsb      = to_lsb;
      issue_d.opcode      = opcode;
      issue_d.funct3      = head.inst[14:12];
      issue_d.funct7b5    = head.inst[30];
      issue_d.rd          = no_rd ? 5'd0 : head.inst[11:7];
      issue_d.rs1_val     = op1.val;
      issue_d.rs1_rob_pos = op1.tag;
      issue_d.rs2_val     = op2.val;
      issue_d.rs2_rob_pos = op2.tag;
      issue_d.imm         = imm;
      issue_d.pc          = head.pc;
      issue_d.pred_jump   = head.pred_jump;
      issue_d.ready_inst  = is_store;
      issue_d.rob_pos     = next_rob_pos_i;
    end
  end

  // Control state registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      issue_q <= '0;
    end else if (rdy_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      issue_q <= issue_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; count_q alone decides which entries are live.
    if (!rst && rdy_i && enq) begin
      mem_q[tail_q] <= '{inst: bus.fetch_inst, pc: bus.fetch_pc, pred_jump: bus.fetch_pred_jump};
    end
  end

  assign bus.issue_enable      = issue_q.enable;
  assign bus.issue_to_rs       = issue_q.to_rs;
  assign bus.issue_to_lsb      = issue_q.to_lsb;
  assign bus.issue_opcode      = issue_q.opcode;
  assign bus.issue_funct3      = issue_q.funct3;
  assign bus.issue_funct7b5    = issue_q.funct7b5;
  assign bus.issue_rd          = issue_q.rd;
  assign bus.issue_rs1_val     = issue_q.rs1_val;
  assign bus.issue_rs2_val     = issue_q.rs2_val;
  assign bus.issue_rs1_rob_pos = issue_q.rs1_rob_pos;
  assign bus.issue_rs2_rob_pos = issue_q.rs2_rob_pos;
  assign bus.issue_imm         = issue_q.imm;
  assign bus.issue_pc          = issue_q.pc;
  assign bus.issue_pred_jump   = issue_q.pred_jump;
  assign bus.issue_ready_inst  = issue_q.ready_inst;
  assign bus.issue_rob_pos     = issue_q.rob_pos;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue with an expected-issue scoreboard.
module tb_decode_issue_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic [4:0]  reg_rs1_pos, reg_rs2_pos;
  logic [31:0] reg_rs1_val, reg_rs2_val;
  logic [3:0]  reg_rs1_rob_pos, reg_rs2_rob_pos;
  logic [3:0]  rob_rs1_pos, rob_rs2_pos;
  logic        rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_val, rob_rs2_val;
  logic [3:0]  next_rob_pos;
  logic        rob_full, rs_full, lsb_full;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_pos;
  logic [63:0] cdb_val;

  int n_assert = 0;
  int n_fail   = 0;
  int n_issue  = 0;

  typedef struct {
    logic        to_rs, to_lsb;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic [31:0] v2;
    logic [3:0]  t2;
    logic [31:0] imm, pc;
    logic        pred, rdyi;
    logic [3:0]  rob;
  } exp_t;

  exp_t sb[$];

  decode_issue_queue_if #(.ROB_W(4)) bus ();

  decode_issue_queue #(.DEPTH(4), .ROB_W(4), .CDB_CH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy_i             (rdy),
    .rollback_i        (rollback),
    .bus               (bus),
    .reg_rs1_pos_o     (reg_rs1_pos),
    .reg_rs2_pos_o     (reg_rs2_pos),
    .reg_rs1_val_i     (reg_rs1_val),
    .reg_rs2_val_i     (reg_rs2_val),
    .reg_rs1_rob_pos_i (reg_rs1_rob_pos),
    .reg_rs2_rob_pos_i (reg_rs2_rob_pos),
    .rob_rs1_pos_o     (rob_rs1_pos),
    .rob_rs2_pos_o     (rob_rs2_pos),
    .rob_rs1_ready_i   (rob_rs1_ready),
    .rob_rs2_ready_i   (rob_rs2_ready),
    .rob_rs1_val_i     (rob_rs1_val),
    .rob_rs2_val_i     (rob_rs2_val),
    .next_rob_pos_i    (next_rob_pos),
    .rob_full_i        (rob_full),
    .rs_full_i         (rs_full),
    .lsb_full_i        (lsb_full),
    .cdb_valid_i       (cdb_valid),
    .cdb_rob_pos_i     (cdb_rob_pos),
    .cdb_val_i         (cdb_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic to_rs, input logic to_lsb, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                      input logic [31:0] v1, input logic [3:0] t1,
                      input logic [31:0] v2, input logic [3:0] t2,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic pred, input logic rdyi, input logic [3:0] rob);
    exp_t e;
    e = '{to_rs, to_lsb, op, f3, f7, rd, v1, t1, v2, t2, imm, pc, pred, rdyi, rob};
    sb.push_back(e);
  endtask

  // One clock; a fresh issue pulse (edge taken with rdy=1) is scored against the queue.
  task automatic tick();
    logic live;
    exp_t e;
    live = rdy && !rst;
    @(posedge clk);
    #1;
    if (live && bus.issue_enable) begin
      n_issue++;
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(bus.issue_enable), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("iss_to_rs",  32'(bus.issue_to_rs),       32'(e.to_rs));
        chk("iss_to_lsb", 32'(bus.issue_to_lsb),      32'(e.to_lsb));
        chk("iss_opcode", 32'(bus.issue_opcode),      32'(e.op));
        chk("iss_funct3", 32'(bus.issue_funct3),      32'(e.f3));
        chk("iss_f7b5",   32'(bus.issue_funct7b5),    32'(e.f7));
        chk("iss_rd",     32'(bus.issue_rd),          32'(e.rd));
        chk("iss_rs1val", bus.issue_rs1_val,          e.v1);
        chk("iss_rs1tag", 32'(bus.issue_rs1_rob_pos), 32'(e.t1));
        chk("iss_rs2val", bus.issue_rs2_val,          e.v2);
        chk("iss_rs2tag", 32'(bus.issue_rs2_rob_pos), 32'(e.t2));
        chk("iss_imm",    bus.issue_imm,              e.imm);
        chk("iss_pc",     bus.issue_pc,               e.pc);
        chk("iss_pred",   32'(bus.issue_pred_jump),   32'(e.pred));
        chk("iss_rdyi",   32'(bus.issue_ready_inst),  32'(e.rdyi));
        chk("iss_robpos", 32'(bus.issue_rob_pos),     32'(e.rob));
      end
    end
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    bus.fetch_valid     = 1'b1;
    bus.fetch_inst      = inst;
    bus.fetch_pc        = pc;
    bus.fetch_pred_jump = pred;
    tick();
    bus.fetch_valid     = 1'b0;
  endtask

  function automatic logic [31:0] add_inst(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  initial begin
    int issue_base;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    bus.fetch_valid = 1'b0; bus.fetch_inst = '0; bus.fetch_pc = '0; bus.fetch_pred_jump = 1'b0;
    reg_rs1_val = '0; reg_rs2_val = '0; reg_rs1_rob_pos = '0; reg_rs2_rob_pos = '0;
    rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0; rob_rs1_val = '0; rob_rs2_val = '0;
    next_rob_pos = '0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    cdb_valid = '0; cdb_rob_pos = '0; cdb_val = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_fetch_ready", 32'(bus.fetch_ready),   32'd1);
    chk("rst_issue_en",    32'(bus.issue_enable),  32'd0);
    chk("rst_issue_imm",   bus.issue_imm,          32'd0);
    chk("rst_issue_pc",    bus.issue_pc,           32'd0);
    chk("rst_issue_to_rs", 32'(bus.issue_to_rs),   32'd0);
    chk("rst_issue_rob",   32'(bus.issue_rob_pos), 32'd0);

    // ADDI x1,x2,-1 with rs1 from regfile, rs2 forced off
    reg_rs1_val = 32'd7; reg_rs2_val = 32'h55; reg_rs2_rob_pos = 4'd5; next_rob_pos = 4'd1;
    push(1, 0, 7'h13, 3'd0, 1, 5'd1, 32'd7, 4'd0, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'h100, 0, 0, 4'd1);
    fetch(32'hFFF1_0093, 32'h100, 1'b0);
    chk("t1_latency_no_issue", 32'(bus.issue_enable), 32'd0);
    chk("t1_head_rs1_idx",     32'(reg_rs1_pos),      32'd2);
    tick();
    chk("t1_issue_pulse",      32'(bus.issue_enable), 32'd1);
    tick();
    chk("t1_pulse_one_cycle",  32'(bus.issue_enable), 32'd0);
    chk("t1_imm_hold",         bus.issue_imm,         32'hFFFF_FFFF);

    // Fill under rs_full, then drain in order on consecutive cycles
    reg_rs1_val = 32'h11; reg_rs2_val = 32'h22; reg_rs2_rob_pos = '0; rs_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_fetch_ready", 32'(bus.fetch_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4)
        push(1, 0, 7'h33, 3'd0, 0, 5'(i + 1), 32'h11, 4'd0, 32'h22, 4'd0, 32'd0,
             32'h200 + 32'(4 * i), 1'(i), 0, 4'(2 + i));
      fetch(add_inst(5'(i + 1), 5'd3, 5'd4), 32'h200 + 32'(4 * i), 1'(i));
      chk("t2_no_issue_full", 32'(bus.issue_enable), 32'd0);
    end
    chk("t2_full_ready_low", 32'(bus.fetch_ready), 32'd0);
    rs_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_rob_pos = 4'(2 + k);
      tick();
      chk("t2_consecutive_issue", 32'(bus.issue_enable), 32'd1);
    end
    tick();
    chk("t2_drained_no_issue", 32'(bus.issue_enable), 32'd0);
    chk("t2_drained_ready",    32'(bus.fetch_ready),  32'd1);

    // CDB bypass: both channels match -> channel 0 wins
    reg_rs1_rob_pos = 4'd3; rob_rs1_ready = 1'b0; reg_rs2_val = 32'h22;
    cdb_valid = 2'b11; cdb_rob_pos = {4'd3, 4'd3}; cdb_val = {32'hB, 32'hA}; next_rob_pos = 4'd6;
    push(1, 0, 7'h33, 3'd0, 0, 5'd3, 32'hA, 4'd0, 32'h22, 4'd0, 32'd0, 32'h300, 0, 0, 4'd6);
    fetch(32'h0020_81B3, 32'h300, 1'b0);
    chk("t3_rob_tag_passthru", 32'(rob_rs1_pos), 32'd3);
    tick();
    // Only channel 1 valid and matching
    cdb_valid = 2'b10; next_rob_pos = 4'd7;
    push(1, 0, 7'h33, 3'd0, 0, 5'd3, 32'hB, 4'd0, 32'h22, 4'd0, 32'd0, 32'h304, 0, 0, 4'd7);
    fetch(32'h0020_81B3, 32'h304, 1'b0);
    tick();
    // No match on rs1 (pending tag 3); rs2 taken from ready ROB entry
    cdb_rob_pos = {4'd5, 4'd3}; reg_rs2_rob_pos = 4'd4; rob_rs2_ready = 1'b1;
    rob_rs2_val = 32'h99; next_rob_pos = 4'd8;
    push(1, 0, 7'h33, 3'd0, 0, 5'd3, 32'd0, 4'd3, 32'h99, 4'd0, 32'd0, 32'h308, 0, 0, 4'd8);
    fetch(32'h0020_81B3, 32'h308, 1'b0);
    tick();
    cdb_valid = '0; reg_rs1_rob_pos = '0; reg_rs2_rob_pos = '0; rob_rs2_ready = 1'b0;

    // SW x1,4(x2): stalls on lsb_full even with rs_full clear
    reg_rs1_val = 32'h1000; reg_rs2_val = 32'h77; lsb_full = 1'b1; next_rob_pos = 4'd9;
    push(0, 1, 7'h23, 3'd2, 0, 5'd0, 32'h1000, 4'd0, 32'h77, 4'd0, 32'd4, 32'h400, 0, 1, 4'd9);
    fetch(32'h0011_2223, 32'h400, 1'b0);
    repeat (3) begin
      tick();
      chk("t4_lsb_stall", 32'(bus.issue_enable), 32'd0);
    end
    lsb_full = 1'b0;
    tick();
    chk("t4_store_issue", 32'(bus.issue_enable), 32'd1);
    tick();

    // Rollback with 3 queued entries and a concurrent fetch
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) fetch(add_inst(5'd1, 5'd1, 5'd1), 32'h500 + 32'(4 * i), 1'b0);
    rs_full = 1'b0; rollback = 1'b1;
    bus.fetch_valid = 1'b1; bus.fetch_inst = add_inst(5'd9, 5'd1, 5'd1); bus.fetch_pc = 32'h5F0;
    tick();
    rollback = 1'b0; bus.fetch_valid = 1'b0;
    chk("t5_rollback_blocks_issue", 32'(bus.issue_enable), 32'd0);
    repeat (3) begin
      tick();
      chk("t5_flushed_no_issue", 32'(bus.issue_enable), 32'd0);
    end
    rs_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_refill_ready", 32'(bus.fetch_ready), 32'd1);
      fetch(add_inst(5'd2, 5'd1, 5'd1), 32'h580 + 32'(4 * i), 1'b0);
    end
    chk("t5_refill_full", 32'(bus.fetch_ready), 32'd0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0; rs_full = 1'b0;
    chk("t5_empty_after_rollback", 32'(bus.fetch_ready), 32'd1);
    tick();
    chk("t5_no_issue_after_flush", 32'(bus.issue_enable), 32'd0);

    // Unknown opcode ahead of LUI, then rdy freeze
    issue_base = n_issue;
    reg_rs1_rob_pos = 4'd2; reg_rs1_val = 32'd5; reg_rs2_rob_pos = 4'd6; reg_rs2_val = 32'h66;
    next_rob_pos = 4'd10;
    push(1, 0, 7'h37, 3'd5, 0, 5'd5, 32'd0, 4'd0, 32'd0, 4'd0, 32'h1234_5000, 32'h604, 0, 0, 4'd10);
    push(1, 0, 7'h13, 3'd0, 1, 5'd1, 32'd0, 4'd2, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'h608, 0, 0, 4'd11);
    fetch(32'h0000_007F, 32'h600, 1'b0);
    chk("t6_no_issue_a", 32'(bus.issue_enable), 32'd0);
    fetch(32'h1234_52B7, 32'h604, 1'b0);
    chk("t6_bad_opcode_silent", 32'(bus.issue_enable), 32'd0);
    fetch(32'hFFF1_0093, 32'h608, 1'b0);
    chk("t6_lui_issue", 32'(bus.issue_enable), 32'd1);
    rdy = 1'b0; next_rob_pos = 4'd11;
    bus.fetch_valid = 1'b1; bus.fetch_inst = add_inst(5'd7, 5'd1, 5'd1); bus.fetch_pc = 32'h700;
    repeat (3) begin
      tick();
      chk("t6_frozen_enable",  32'(bus.issue_enable),  32'd1);
      chk("t6_frozen_imm",     bus.issue_imm,          32'h1234_5000);
      chk("t6_frozen_rob",     32'(bus.issue_rob_pos), 32'd10);
      chk("t6_frozen_head",    32'(reg_rs1_pos),       32'd2);
    end
    rdy = 1'b1; bus.fetch_valid = 1'b0;
    tick();
    chk("t6_addi_issue", 32'(bus.issue_enable), 32'd1);
    tick();
    chk("t6_idle", 32'(bus.issue_enable), 32'd0);
    chk("t6_issue_count", 32'(n_issue - issue_base), 32'd2);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
